// File: rtl/ita_gelu_requant.sv
// Requantizes signed GELU results to saturated int8 and buffers them in a small output FIFO.
// Latency: sample at edge N is written to the FIFO at edge N+1, so it is visible right after N+1 when the FIFO was empty.
// Backpressure: consumer stalls via io_ready_i; the input side cannot stall, so samples hitting a full FIFO are dropped and flagged.
//
// Ports:
//   io_clk, io_rst_ni        clock, asynchronous active-low reset
//   io_clear_i               synchronous flush of stage 1, FIFO and overflow flag
//   io_valid_i, io_data_i    GELU result (signed, IN_W bits) with its valid
//   io_mult_i/shift_i/add_i  requant parameters, sampled together with io_valid_i
//   io_valid_o, io_ready_i   output handshake on the FIFO head
//   io_data_o                int8 result at the FIFO head (0 while empty)
//   io_count_o               FIFO occupancy
//   io_overflow_o            sticky drop indicator
module ita_gelu_requant #(
  parameter int unsigned IN_W    = 26,
  parameter int unsigned MULT_W  = 8,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     io_clk,
  input  logic                     io_rst_ni,
  input  logic                     io_clear_i,
  input  logic                     io_valid_i,
  input  logic [IN_W-1:0]          io_data_i,
  input  logic [MULT_W-1:0]        io_mult_i,
  input  logic [SHIFT_W-1:0]       io_shift_i,
  input  logic [OUT_W-1:0]         io_add_i,
  output logic                     io_valid_o,
  input  logic                     io_ready_i,
  output logic [OUT_W-1:0]         io_data_o,
  output logic [$clog2(DEPTH):0]   io_count_o,
  output logic                     io_overflow_o
);

  localparam int unsigned PROD_W = IN_W + MULT_W + 1;
  localparam int unsigned EXT_W  = PROD_W + 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  // Saturation bounds sign-extended to the stage-2 width.
  localparam logic signed [EXT_W-1:0] OUT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] OUT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // ---------------- Stage 1: multiply ----------------
  logic                     s1Valid;
  logic signed [PROD_W-1:0] prodQ;
  logic [SHIFT_W-1:0]       shiftQ;
  logic [OUT_W-1:0]         addQ;
  logic signed [PROD_W-1:0] prodD;

  // Both operands widened to the full product width; the multiplier is zero-extended (unsigned).
  assign prodD = $signed({{(MULT_W+1){io_data_i[IN_W-1]}}, io_data_i})
               * $signed({{(IN_W+1){1'b0}}, io_mult_i});

  always_ff @(posedge io_clk or negedge io_rst_ni) begin
    if (!io_rst_ni) begin
      s1Valid <= 1'b0;
      prodQ   <= '0;
      shiftQ  <= '0;
      addQ    <= '0;
    end else begin
      s1Valid <= io_valid_i && !io_clear_i;
      if (io_valid_i && !io_clear_i) begin
        prodQ  <= prodD;
        shiftQ <= io_shift_i;
        addQ   <= io_add_i;
      end
    end
  end

  // ---------------- Stage 2: round, shift, offset, clamp ----------------
  logic [SHIFT_W-1:0]      shiftM1;
  logic signed [EXT_W-1:0] rndVal;
  logic signed [EXT_W-1:0] prodExt;
  logic signed [EXT_W-1:0] tVal;
  logic signed [EXT_W-1:0] addExt;
  logic signed [EXT_W-1:0] uVal;
  logic [OUT_W-1:0]        outD;

  assign shiftM1 = shiftQ - SHIFT_W'(1);
  // Half-LSB rounding term; adding it before the arithmetic shift rounds ties toward +inf.
  assign rndVal  = (shiftQ == '0) ? '0 : (EXT_W'(1) << shiftM1);
  assign prodExt = {prodQ[PROD_W-1], prodQ};
  assign tVal    = (prodExt + rndVal) >>> shiftQ;
  assign addExt  = {{(EXT_W-OUT_W){addQ[OUT_W-1]}}, addQ};
  assign uVal    = tVal + addExt;

  always_comb begin
    outD = uVal[OUT_W-1:0];
    if (uVal > OUT_MAX) begin
      outD = OUT_MAX[OUT_W-1:0];
    end else if (uVal < OUT_MIN) begin
      outD = OUT_MIN[OUT_W-1:0];
    end
  end

  // ---------------- Output FIFO ----------------
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             full;
  logic             popEn;
  logic             pushEn;
  logic             dropEn;

  assign full   = (count == CNT_W'(DEPTH));
  assign popEn  = io_valid_o && io_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pushEn = s1Valid && (!full || popEn);
  assign dropEn = s1Valid && full && !popEn;

  always_ff @(posedge io_clk or negedge io_rst_ni) begin
    if (!io_rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (io_clear_i) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushEn) begin
        mem[wrPtr] <= outD;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (dropEn) begin
        overflow <= 1'b1;
      end
    end
  end

  assign io_valid_o    = (count != '0);
  // Forced to 0 while empty so stale storage left behind by a flush is never exposed.
  assign io_data_o     = io_valid_o ? mem[rdPtr] : '0;
  assign io_count_o    = count;
  assign io_overflow_o = overflow;

endmodule

// File: tb/tb_ita_gelu_requant.sv
// Testbench for ita_gelu_requant: directed scenarios followed by randomized traffic,
// checked cycle by cycle against a queue-based reference model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ita_gelu_requant;

  localparam int DEPTH = 4;

  logic              io_clk = 1'b0;
  logic              io_rst_ni = 1'b0;
  logic              clearI = 1'b0;
  logic              validI = 1'b0;
  logic signed [25:0] dataI = '0;
  logic [7:0]        multI = '0;
  logic [4:0]        shiftI = '0;
  logic signed [7:0] addI = '0;
  logic              readyI = 1'b0;
  logic              validO;
  logic signed [7:0] dataO;
  logic [2:0]        countO;
  logic              overflowO;

  int totalN = 0;
  int badN = 0;

  // Reference model state
  int  q[$];
  bit  mS1V = 1'b0;
  int  mS1Val = 0;
  bit  mOvf = 1'b0;

  always #5 io_clk = ~io_clk;

  ita_gelu_requant #(
    .IN_W(26), .MULT_W(8), .SHIFT_W(5), .OUT_W(8), .DEPTH(DEPTH)
  ) dut (
    .io_clk       (io_clk),
    .io_rst_ni    (io_rst_ni),
    .io_clear_i   (clearI),
    .io_valid_i   (validI),
    .io_data_i    (dataI),
    .io_mult_i    (multI),
    .io_shift_i   (shiftI),
    .io_add_i     (addI),
    .io_valid_o   (validO),
    .io_ready_i   (readyI),
    .io_data_o    (dataO),
    .io_count_o   (countO),
    .io_overflow_o(overflowO)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    totalN++;
    if (obs !== exp) begin
      badN++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Requantization straight from the arithmetic definition.
  function automatic int refOut(input longint d, input longint m, input int sh, input longint a);
    longint prod, rnd, t, u;
    prod = d * m;
    rnd  = (sh == 0) ? 64'sd0 : (64'sd1 <<< (sh - 1));
    t    = (prod + rnd) >>> sh;
    u    = t + a;
    if (u > 127) u = 127;
    if (u < -128) u = -128;
    return int'(u);
  endfunction

  task automatic modelReset();
    q.delete();
    mS1V = 1'b0;
    mS1Val = 0;
    mOvf = 1'b0;
  endtask

  task automatic checkOutputs();
    chk("valid", longint'(validO), longint'(q.size() > 0));
    chk("data", longint'(dataO), (q.size() > 0) ? longint'(q[0]) : 64'sd0);
    chk("count", longint'(countO), longint'(q.size()));
    chk("ovf", longint'(overflowO), longint'(mOvf));
  endtask

  // One clock: model update at the rising edge, output check at the falling edge.
  task automatic step();
    @(posedge io_clk);
    if (!io_rst_ni) begin
      modelReset();
    end else if (clearI) begin
      modelReset();
    end else begin
      if (q.size() > 0 && readyI) void'(q.pop_front());
      if (mS1V) begin
        if (q.size() < DEPTH) q.push_back(mS1Val);
        else mOvf = 1'b1;
      end
      mS1V = validI;
      if (validI) mS1Val = refOut(longint'(dataI), longint'(multI), int'(shiftI), longint'(addI));
    end
    @(negedge io_clk);
    checkOutputs();
  endtask

  task automatic send(input int d, input int m, input int sh, input int a, input bit rdy);
    validI = 1'b1;
    dataI  = 26'(d);
    multI  = 8'(m);
    shiftI = 5'(sh);
    addI   = 8'(a);
    readyI = rdy;
    step();
    validI = 1'b0;
  endtask

  task automatic idle(input bit rdy, input int n);
    validI = 1'b0;
    readyI = rdy;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", longint'(validO), 0);
    chk("rst_data", longint'(dataO), 0);
    chk("rst_count", longint'(countO), 0);
    chk("rst_ovf", longint'(overflowO), 0);
    @(negedge io_clk);
    io_rst_ni = 1'b1;
    idle(1'b1, 2);

    // 1. Basic path and latency
    send(1000, 32, 8, 0, 1'b1);
    chk("t1_lat0", longint'(validO), 0);
    step();
    chk("t1_valid", longint'(validO), 1);
    chk("t1_data", longint'(dataO), 125);
    step();
    send(1000, 32, 8, -3, 1'b1);
    step();
    chk("t1_add", longint'(dataO), 122);
    idle(1'b1, 2);

    // 2. Negative rounding and shift 0
    send(-1000, 32, 8, 0, 1'b1);
    step();
    chk("t2_neg", longint'(dataO), -125);
    send(3, 1, 0, 0, 1'b1);
    step();
    chk("t2_sh0", longint'(dataO), 3);
    idle(1'b1, 2);

    // 3. Saturation
    send(100000, 255, 0, 0, 1'b1);
    step();
    chk("t3_pos", longint'(dataO), 127);
    send(-100000, 255, 0, 0, 1'b1);
    step();
    chk("t3_neg", longint'(dataO), -128);
    send(0, 0, 0, -128, 1'b1);
    step();
    chk("t3_add", longint'(dataO), -128);
    idle(1'b1, 2);

    // 4. Backpressure and overflow
    for (int k = 1; k <= 5; k++) send(k, 1, 0, 0, 1'b0);
    idle(1'b0, 1);
    chk("t4_count", longint'(countO), 4);
    chk("t4_ovf", longint'(overflowO), 1);
    readyI = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_drain", longint'(dataO), k);
      step();
    end
    chk("t4_empty", longint'(countO), 0);
    chk("t4_sticky", longint'(overflowO), 1);

    // 6a. Clear with 3 entries held and one sample in flight
    for (int k = 1; k <= 4; k++) send(10 + k, 1, 0, 0, 1'b0);
    chk("t6_held", longint'(countO), 3);
    clearI = 1'b1;
    step();
    clearI = 1'b0;
    chk("t6_count", longint'(countO), 0);
    chk("t6_valid", longint'(validO), 0);
    chk("t6_ovf", longint'(overflowO), 0);
    idle(1'b0, 2);
    chk("t6_noflight", longint'(countO), 0);

    // 5. Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) send(k, 1, 0, 0, 1'b0);
    idle(1'b0, 1);
    chk("t5_full", longint'(countO), 4);
    send(6, 1, 0, 0, 1'b0);
    readyI = 1'b1;
    step();
    readyI = 1'b0;
    chk("t5_count", longint'(countO), 4);
    chk("t5_ovf", longint'(overflowO), 0);
    readyI = 1'b1;
    chk("t5_d0", longint'(dataO), 2); step();
    chk("t5_d1", longint'(dataO), 3); step();
    chk("t5_d2", longint'(dataO), 4); step();
    chk("t5_d3", longint'(dataO), 6); step();
    chk("t5_empty", longint'(validO), 0);

    // 6b. Asynchronous reset mid-stream
    for (int k = 1; k <= 3; k++) send(20 + k, 1, 0, 0, 1'b0);
    validI = 1'b1;
    readyI = 1'b1;
    #2;
    io_rst_ni = 1'b0;
    #1;
    modelReset();
    chk("t6r_valid", longint'(validO), 0);
    chk("t6r_data", longint'(dataO), 0);
    chk("t6r_count", longint'(countO), 0);
    chk("t6r_ovf", longint'(overflowO), 0);
    step();
    step();
    io_rst_ni = 1'b1;
    validI = 1'b0;
    send(1000, 32, 8, 0, 1'b1);
    step();
    chk("t6r_resume", longint'(dataO), 125);
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      validI = ($urandom_range(0, 9) < 7);
      readyI = ($urandom_range(0, 9) < 6);
      clearI = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 2))
        0: dataI = 26'($urandom);
        1: dataI = 26'($signed(12'($urandom)));
        default: dataI = 26'($signed(20'($urandom)));
      endcase
      multI  = 8'($urandom);
      shiftI = 5'($urandom);
      addI   = 8'($urandom);
      step();
    end
    clearI = 1'b0;
    idle(1'b1, 8);

    $display("test done: total=%0d bad=%0d", totalN, badN);
    $finish;
  end

endmodule
